// File: rtl/video_capture.sv
// Composite 1-bit video capture: splits H/V sync by low-pulse width, tracks line
// number and packs luma samples inside the active window into frame-buffer bytes.
module video_capture #(
    parameter int HS_MIN       = 32,
    parameter int VS_MIN       = 400,
    parameter int PIX_START    = 186,
    parameter int VS_LIN       = 248,
    parameter int BK_TOP       = 16,
    parameter int BK_BOT       = 240,
    parameter int MAX_V        = 261,
    parameter int LOST_TIMEOUT = 2047
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic        luma_i,
    input  logic        sync_i,
    output logic        wr_en_o,
    output logic [12:0] wr_addr_o,
    output logic [7:0]  wr_data_o,
    output logic        frame_done_o,
    output logic        locked_o
);

    localparam logic [9:0]  HsMinW    = 10'(HS_MIN);
    localparam logic [9:0]  VsMinW    = 10'(VS_MIN);
    localparam logic [10:0] PixStartW = 11'(PIX_START);
    localparam logic [10:0] TimeoutW  = 11'(LOST_TIMEOUT);
    localparam logic [8:0]  VsLinW    = 9'(VS_LIN);
    localparam logic [8:0]  BkTopW    = 9'(BK_TOP);
    localparam logic [8:0]  BkBotW    = 9'(BK_BOT);
    localparam logic [8:0]  MaxVW     = 9'(MAX_V);
    localparam logic [7:0]  BkTop8    = 8'(BK_TOP);
    localparam logic [12:0] LastAddr  = 13'((BK_BOT - BK_TOP) * 32 - 1);

    logic        lumaMeta_q, lumaSync_q, syncMeta_q, syncSync_q;
    logic [9:0]  lowCnt_q, lowCnt_d;
    logic [10:0] hCnt_q, hCnt_d;
    logic [8:0]  vLine_q, vLine_d;
    logic        locked_q, locked_d;
    logic        enLine_q, enLine_d;
    logic [8:0]  kCnt_q, kCnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        wrEn_q, wrEn_d;
    logic [12:0] wrAddr_q, wrAddr_d;
    logic [7:0]  wrData_q, wrData_d;
    logic        frameDone_q, frameDone_d;

    logic        syncRise, isHSync, isVSync, lineActive, sampleHit;
    logic [10:0] sampleAt;
    logic [7:0]  lineIdx;

    // lowCnt is non-zero only while sync is low, so a high sync with a non-zero
    // count marks the rising edge and the count is the pulse width.
    assign syncRise   = syncSync_q && (lowCnt_q != 10'd0);
    assign isHSync    = syncRise && (lowCnt_q >= HsMinW) && (lowCnt_q < VsMinW);
    assign isVSync    = syncRise && (lowCnt_q >= VsMinW);
    assign lineActive = locked_q && enLine_q && (vLine_q >= BkTopW) && (vLine_q < BkBotW);
    assign sampleAt   = PixStartW + {2'b00, kCnt_q} + {1'b0, kCnt_q, 1'b0};
    assign sampleHit  = lineActive && !kCnt_q[8] && (hCnt_q == sampleAt);
    assign lineIdx    = vLine_q[7:0] - BkTop8;

    always_comb begin
        lowCnt_d    = lowCnt_q;
        hCnt_d      = hCnt_q;
        vLine_d     = vLine_q;
        locked_d    = locked_q;
        enLine_d    = enLine_q;
        kCnt_d      = kCnt_q;
        shift_d     = shift_q;
        wrEn_d      = 1'b0;
        wrAddr_d    = wrAddr_q;
        wrData_d    = wrData_q;
        frameDone_d = wrEn_q && (wrAddr_q == LastAddr);

        if (syncSync_q) begin
            lowCnt_d = 10'd0;
        end else if (lowCnt_q != 10'h3FF) begin
            lowCnt_d = lowCnt_q + 10'd1;
        end

        if (hCnt_q != 11'h7FF) begin
            hCnt_d = hCnt_q + 11'd1;
        end

        if (hCnt_q == TimeoutW) begin
            locked_d = 1'b0;
        end

        // A valid sync restarts the line and throws away any partial byte.
        if (isHSync) begin
            hCnt_d   = {1'b0, lowCnt_q};
            vLine_d  = (vLine_q == MaxVW) ? 9'd0 : vLine_q + 9'd1;
            enLine_d = enable_i;
            kCnt_d   = 9'd0;
            shift_d  = 8'd0;
        end else if (isVSync) begin
            locked_d = (vLine_q == VsLinW);
            hCnt_d   = {1'b0, lowCnt_q};
            vLine_d  = VsLinW;
            kCnt_d   = 9'd0;
            shift_d  = 8'd0;
        end else if (sampleHit) begin
            shift_d = {shift_q[6:0], lumaSync_q};
            kCnt_d  = kCnt_q + 9'd1;
            if (kCnt_q[2:0] == 3'd7) begin
                wrEn_d   = 1'b1;
                wrData_d = {shift_q[6:0], lumaSync_q};
                wrAddr_d = {lineIdx, kCnt_q[7:3]};
            end
        end
    end

    // Synchronizers idle high on sync so leaving reset does not look like a pulse.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lumaMeta_q  <= 1'b0;
            lumaSync_q  <= 1'b0;
            syncMeta_q  <= 1'b1;
            syncSync_q  <= 1'b1;
            lowCnt_q    <= 10'd0;
            hCnt_q      <= 11'd0;
            vLine_q     <= 9'd0;
            locked_q    <= 1'b0;
            enLine_q    <= 1'b0;
            kCnt_q      <= 9'd0;
            shift_q     <= 8'd0;
            wrEn_q      <= 1'b0;
            wrAddr_q    <= 13'd0;
            wrData_q    <= 8'd0;
            frameDone_q <= 1'b0;
        end else begin
            lumaMeta_q  <= luma_i;
            lumaSync_q  <= lumaMeta_q;
            syncMeta_q  <= sync_i;
            syncSync_q  <= syncMeta_q;
            lowCnt_q    <= lowCnt_d;
            hCnt_q      <= hCnt_d;
            vLine_q     <= vLine_d;
            locked_q    <= locked_d;
            enLine_q    <= enLine_d;
            kCnt_q      <= kCnt_d;
            shift_q     <= shift_d;
            wrEn_q      <= wrEn_d;
            wrAddr_q    <= wrAddr_d;
            wrData_q    <= wrData_d;
            frameDone_q <= frameDone_d;
        end
    end

    assign wr_en_o      = wrEn_q;
    assign wr_addr_o    = wrAddr_q;
    assign wr_data_o    = wrData_q;
    assign frame_done_o = frameDone_q;
    assign locked_o     = locked_q;

endmodule

// File: tb/tb_video_capture.sv
// Directed bench for video_capture: synthetic sync/luma lines with hand-computed
// write addresses, data, lock behaviour and frame_done timing.
module tb_video_capture;

    logic        clk = 1'b0;
    logic        reset, enable, luma, sync;
    logic        wr_en, frame_done, locked;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;

    int compareCount = 0;
    int mismatchCount = 0;
    int cyc = 0;
    int fdCount = 0;
    int fdCyc = 0;
    int lastWrCyc = 0;
    logic [12:0] wrAddrQ[$];
    logic [7:0]  wrDataQ[$];

    video_capture dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .enable_i    (enable),
        .luma_i      (luma),
        .sync_i      (sync),
        .wr_en_o     (wr_en),
        .wr_addr_o   (wr_addr),
        .wr_data_o   (wr_data),
        .frame_done_o(frame_done),
        .locked_o    (locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write collector; every write must also happen while locked.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wrAddrQ.push_back(wr_addr);
            wrDataQ.push_back(wr_data);
            lastWrCyc = cyc;
            compareCount++;
            if (locked !== 1'b1) begin
                mismatchCount++;
                $display("[TB] FAIL wr_while_unlocked: locked=%b required 1 (addr %0d)", locked, wr_addr);
            end
        end
        if (frame_done === 1'b1) begin
            fdCount++;
            fdCyc = cyc;
        end
    end

    function automatic logic lumaAt(input int mode, input int t);
        int k;
        if (mode == 1) return (t >= 185 && t <= 187);
        if (t < 186) return 1'b0;
        k = (t - 186) / 3;
        if (k > 255) return 1'b0;
        if (mode == 2) return (k % 2 == 0);
        if (mode == 3) return 1'b1;
        return 1'b0;
    endfunction

    // One line from sync fall to next fall; during the low phase luma may carry on
    // the previous line's pattern so a cut-short line keeps sampling correctly.
    task automatic driveLine(input int lowLen, input int period, input logic en, input int mode,
                             input int glitchAt, input int carryMode, input int carryOff);
        enable = en;
        for (int t = 0; t < period; t++) begin
            @(posedge clk);
            #2;
            sync = (t < lowLen) ? 1'b0 : 1'b1;
            if (glitchAt >= 0 && t >= glitchAt && t < glitchAt + 10) sync = 1'b0;
            if (carryMode >= 0 && t < lowLen) luma = lumaAt(carryMode, t + carryOff);
            else luma = lumaAt(mode, t);
        end
    endtask

    task automatic shortLines(input int n, input logic en);
        for (int i = 0; i < n; i++) driveLine(40, 50, en, 0, -1, -1, 0);
    endtask

    task automatic vSync();
        driveLine(942, 972, 1'b0, 0, -1, -1, 0);
    endtask

    task automatic clearWrites();
        wrAddrQ.delete();
        wrDataQ.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; sync = 1'b1; luma = 1'b0; enable = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        compareCount += 5;
        if (wr_en !== 1'b0) begin mismatchCount++; $display("[TB] FAIL reset_wr_en: got %b want 0", wr_en); end
        if (wr_addr !== 13'd0) begin mismatchCount++; $display("[TB] FAIL reset_wr_addr: got %0d want 0", wr_addr); end
        if (wr_data !== 8'd0) begin mismatchCount++; $display("[TB] FAIL reset_wr_data: got %h want 00", wr_data); end
        if (frame_done !== 1'b0) begin mismatchCount++; $display("[TB] FAIL reset_frame_done: got %b want 0", frame_done); end
        if (locked !== 1'b0) begin mismatchCount++; $display("[TB] FAIL reset_locked: got %b want 0", locked); end
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic test_lock_acquire();
        vSync();
        compareCount++;
        if (locked !== 1'b0) begin mismatchCount++; $display("[TB] FAIL lock_first_vsync: got %b want 0", locked); end
        shortLines(262, 1'b0);
        vSync();
        compareCount++;
        if (locked !== 1'b1) begin mismatchCount++; $display("[TB] FAIL lock_second_vsync: got %b want 1", locked); end
    endtask

    task automatic test_synthetic();
        logic [7:0] expData;
        shortLines(29, 1'b0);
        clearWrites();
        driveLine(75, 1015, 1'b1, 1, -1, -1, 0);
        compareCount++;
        if (wrAddrQ.size() != 32) begin mismatchCount++; $display("[TB] FAIL synth_count: got %0d want 32", wrAddrQ.size()); end
        for (int i = 0; i < wrAddrQ.size() && i < 32; i++) begin
            expData = (i == 0) ? 8'h80 : 8'h00;
            compareCount += 2;
            if (wrAddrQ[i] !== 13'(i)) begin mismatchCount++; $display("[TB] FAIL synth_addr[%0d]: got %0d want %0d", i, wrAddrQ[i], i); end
            if (wrDataQ[i] !== expData) begin mismatchCount++; $display("[TB] FAIL synth_data[%0d]: got %h want %h", i, wrDataQ[i], expData); end
        end
    endtask

    task automatic test_glitch();
        clearWrites();
        driveLine(75, 1015, 1'b1, 2, 501, -1, 0);
        compareCount++;
        if (wrAddrQ.size() != 32) begin mismatchCount++; $display("[TB] FAIL glitch_count: got %0d want 32", wrAddrQ.size()); end
        for (int i = 0; i < wrAddrQ.size() && i < 32; i++) begin
            compareCount += 2;
            if (wrAddrQ[i] !== 13'(32 + i)) begin mismatchCount++; $display("[TB] FAIL glitch_addr[%0d]: got %0d want %0d", i, wrAddrQ[i], 32 + i); end
            if (wrDataQ[i] !== 8'hAA) begin mismatchCount++; $display("[TB] FAIL glitch_data[%0d]: got %h want aa", i, wrDataQ[i]); end
        end
    endtask

    // Line 18 is cut by an H sync falling at hcnt 430; its edge lands between the
    // 8th sample of byte 12 and of byte 13, so bytes 0..12 are written.
    task automatic test_early_sync();
        logic [12:0] expAddr;
        logic [7:0]  expData;
        clearWrites();
        driveLine(75, 431, 1'b1, 2, -1, -1, 0);
        driveLine(75, 1015, 1'b1, 3, -1, 2, 431);
        compareCount++;
        if (wrAddrQ.size() != 45) begin mismatchCount++; $display("[TB] FAIL early_count: got %0d want 45", wrAddrQ.size()); end
        for (int i = 0; i < wrAddrQ.size() && i < 45; i++) begin
            expAddr = (i < 13) ? 13'(64 + i) : 13'(96 + i - 13);
            expData = (i < 13) ? 8'hAA : 8'hFF;
            compareCount += 2;
            if (wrAddrQ[i] !== expAddr) begin mismatchCount++; $display("[TB] FAIL early_addr[%0d]: got %0d want %0d", i, wrAddrQ[i], expAddr); end
            if (wrDataQ[i] !== expData) begin mismatchCount++; $display("[TB] FAIL early_data[%0d]: got %h want %h", i, wrDataQ[i], expData); end
        end
    endtask

    task automatic test_frame_done();
        shortLines(219, 1'b0);
        clearWrites();
        fdCount = 0;
        driveLine(75, 1015, 1'b1, 0, -1, -1, 0);
        compareCount += 3;
        if (wrAddrQ.size() != 32) begin mismatchCount++; $display("[TB] FAIL fd_count_writes: got %0d want 32", wrAddrQ.size()); end
        if (fdCount != 1) begin mismatchCount++; $display("[TB] FAIL fd_pulses: got %0d want 1", fdCount); end
        if (fdCyc != lastWrCyc + 1) begin mismatchCount++; $display("[TB] FAIL fd_timing: got cycle %0d want %0d", fdCyc, lastWrCyc + 1); end
        for (int i = 0; i < wrAddrQ.size() && i < 32; i++) begin
            compareCount += 2;
            if (wrAddrQ[i] !== 13'(7136 + i)) begin mismatchCount++; $display("[TB] FAIL fd_addr[%0d]: got %0d want %0d", i, wrAddrQ[i], 7136 + i); end
            if (wrDataQ[i] !== 8'h00) begin mismatchCount++; $display("[TB] FAIL fd_data[%0d]: got %h want 00", i, wrDataQ[i]); end
        end
    endtask

    task automatic test_wrong_frame();
        shortLines(11, 1'b0);
        vSync();
        compareCount++;
        if (locked !== 1'b0) begin mismatchCount++; $display("[TB] FAIL wrong_len_unlock: got %b want 0", locked); end
        shortLines(262, 1'b0);
        compareCount++;
        if (locked !== 1'b0) begin mismatchCount++; $display("[TB] FAIL wrong_len_still_unlocked: got %b want 0", locked); end
        vSync();
        compareCount++;
        if (locked !== 1'b1) begin mismatchCount++; $display("[TB] FAIL wrong_len_relock: got %b want 1", locked); end
    endtask

    task automatic test_lock_loss();
        shortLines(5, 1'b0);
        clearWrites();
        driveLine(40, 2040, 1'b1, 0, -1, -1, 0);
        @(negedge clk);
        compareCount++;
        if (locked !== 1'b1) begin mismatchCount++; $display("[TB] FAIL loss_before_timeout: got %b want 1", locked); end
        repeat (100) @(posedge clk);
        @(negedge clk);
        compareCount += 2;
        if (locked !== 1'b0) begin mismatchCount++; $display("[TB] FAIL loss_after_timeout: got %b want 0", locked); end
        if (wrAddrQ.size() != 0) begin mismatchCount++; $display("[TB] FAIL loss_writes: got %0d want 0", wrAddrQ.size()); end
        vSync();
        compareCount++;
        if (locked !== 1'b0) begin mismatchCount++; $display("[TB] FAIL loss_first_vsync: got %b want 0", locked); end
        shortLines(262, 1'b1);
        compareCount++;
        if (wrAddrQ.size() != 0) begin mismatchCount++; $display("[TB] FAIL loss_unlocked_writes: got %0d want 0", wrAddrQ.size()); end
        vSync();
        compareCount++;
        if (locked !== 1'b1) begin mismatchCount++; $display("[TB] FAIL loss_relock: got %b want 1", locked); end
    endtask

    task automatic test_mid_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        compareCount += 2;
        if (locked !== 1'b0) begin mismatchCount++; $display("[TB] FAIL midreset_locked: got %b want 0", locked); end
        if (wr_en !== 1'b0) begin mismatchCount++; $display("[TB] FAIL midreset_wr_en: got %b want 0", wr_en); end
        #2 reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_synthetic();
        test_glitch();
        test_early_sync();
        test_frame_done();
        test_wrong_frame();
        test_lock_loss();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
